// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
// Holds the FSM state encoding and the default counter width.
package timer_pkg;

  localparam int TIMER_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/timer_n.sv
// Loadable countdown timer advanced by an external en_tick strobe.
// Defining TIMER_AUTORELOAD_EN adds a reload input that restarts the countdown from DONE.
module timer_n
  import timer_pkg::*;
#(
  parameter int BITS = TIMER_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_tick,
  input  logic            start,
  input  logic [BITS-1:0] load_val,
  input  logic            abort,
`ifdef TIMER_AUTORELOAD_EN
  input  logic            reload,
`endif
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] q
);

  localparam logic [BITS-1:0] ONE  = BITS'(1);
  localparam logic [BITS-1:0] ZERO = '0;

  state_t          state, next_state;
  logic [BITS-1:0] count, next_count;
  logic [BITS-1:0] period, next_period;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= ZERO;
      period <= ZERO;
    end else begin
      state  <= next_state;
      count  <= next_count;
      period <= next_period;
    end
  end

  // A zero-length load skips RUN; the count never decrements below zero.
  always_comb begin
    next_state  = state;
    next_count  = count;
    next_period = period;
    case (state)
      IDLE: begin
        if (start) begin
          next_count  = load_val;
          next_period = load_val;
          next_state  = (load_val == ZERO) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          next_count = ZERO;
          next_state = IDLE;
        end else if (en_tick) begin
          if (count > ONE) begin
            next_count = count - ONE;
          end else begin
            next_count = ZERO;
            next_state = DONE;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
`ifdef TIMER_AUTORELOAD_EN
        if (!abort && reload && (period != ZERO)) begin
          next_count = period;
          next_state = RUN;
        end
`endif
      end
      default: begin
        next_count = ZERO;
        next_state = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign q    = count;

endmodule
